// File: rtl/isa_shared_pkg.sv
// Shared RV32I types used by the load/store path.
//   mem_access_type_e : access width decoded from funct3[1:0]
//   i_function3_e     : load funct3 encodings
//   s_function3_e     : store funct3 encodings
//   lsu_state_e       : load/store sequencer states
//   lsu_err_e         : completion status reported with done_valid
package isa_shared;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_access_type_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } i_function3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } s_function3_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_e;

    // Loads and stores share the size encoding in funct3[1:0].
    function automatic mem_access_type_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            default: return MEM_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_controller_align.sv
// Combinational funct3/alignment decode and data lane handling for the LSU.
// Request side (driven straight from the execute-stage request):
//   store, funct3, offset, wdata -> illegal, misaligned, wstrb, wdata_rep
// Response side (driven from the fields latched at accept):
//   ld_funct3, ld_offset, rdata  -> ld_data (sign/zero-extended load result)
module lsu_align
    import isa_shared::*;
(
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    mem_access_type_e size;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    assign size = f3_size(funct3);

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        wstrb      = 4'b0000;
        wdata_rep  = wdata;

        if (store) begin
            illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
        end else begin
            illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end

        case (size)
            MEM_BYTE: begin
                wstrb     = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_HALF: begin
                misaligned = offset[0];
                wstrb      = 4'b0011 << offset;
                wdata_rep  = {2{wdata[15:0]}};
            end
            default: begin
                misaligned = (offset != 2'b00);
                wstrb      = 4'b1111;
                wdata_rep  = wdata;
            end
        endcase
    end

    assign byte_sel = rdata[{ld_offset, 3'b000} +: 8];
    assign half_sel = ld_offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_data = rdata;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  ld_data = {24'h000000, byte_sel};
            F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  ld_data = {16'h0000, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// RV32I load/store sequencer: one LOAD/STORE in flight between the execute
// stage and a single-port req/gnt/rvalid data bus.
//   req_*  : execute-stage handshake (req_ready high only in IDLE)
//   mem_*  : registered bus request; mem_gnt/mem_rvalid from the bus
//   wb_*   : one-cycle load writeback (fires for rd=0 as well)
//   done_valid/err_code : one-cycle retire pulse with completion status
//
// state | meaning
// IDLE  | ready for a new op; illegal/misaligned ops go straight to RESP
// REQ   | mem_req asserted with stable fields until mem_gnt
// WAIT  | granted, waiting for mem_rvalid (read data or write ack)
// RESP  | done_valid (and wb_valid for loads) visible for one cycle
module lsu_controller
    import isa_shared::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done_valid,
    output logic [1:0]  err_code
);

    // One spare bit so a count that passes the limit inside WAIT still compares high.
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    lsu_state_e  state_q, state_d;
    lsu_err_e    err_d;
    logic [CW-1:0] cnt_q;
    logic        accept;
    logic        timeout;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  wstrb;
    logic [31:0] wdata_rep;
    logic [31:0] ld_data;

    lsu_align u_align (
        .store      (req_store),
        .funct3     (req_funct3),
        .offset     (req_addr[1:0]),
        .wdata      (req_wdata),
        .illegal    (illegal),
        .misaligned (misaligned),
        .wstrb      (wstrb),
        .wdata_rep  (wdata_rep),
        .ld_funct3  (f3_q),
        .ld_offset  (off_q),
        .rdata      (mem_rdata),
        .ld_data    (ld_data)
    );

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    // cnt_q is 0 in the first REQ cycle, so this fires in the TIMEOUT_CYCLES-th
    // REQ/WAIT cycle; mem_req and the timeout retire then take effect together.
    assign timeout   = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        state_d = RESP;
                        err_d   = ERR_ILLEGAL;
                    end else if (misaligned) begin
                        state_d = RESP;
                        err_d   = ERR_MISALIGN;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A grant in the last allowed cycle still wins over the timeout.
                if (mem_gnt) begin
                    state_d = WAIT;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            store_q    <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'h0;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'h0;
            done_valid <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            mem_req    <= (state_d == REQ);
            done_valid <= (state_d == RESP);
            err_code   <= err_d;
            wb_valid   <= (state_q == WAIT) && mem_rvalid && !store_q;

            if (state_q == REQ || state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (accept) begin
                cnt_q   <= '0;
                store_q <= req_store;
                f3_q    <= req_funct3;
                off_q   <= req_addr[1:0];
                wb_rd   <= req_rd;
                // Rejected ops leave the bus fields untouched.
                if (!illegal && !misaligned) begin
                    mem_we    <= req_store;
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_wstrb <= req_store ? wstrb : 4'b0000;
                    mem_wdata <= req_store ? wdata_rep : 32'h0;
                end
            end

            if ((state_q == WAIT) && mem_rvalid && !store_q) begin
                wb_data <= ld_data;
            end
        end
    end

endmodule
